// File: rtl/apb3_manager_bridge_if.sv
// Bundles the request/response port and the APB3 manager signals of apb3_manager_bridge.
// The master modport is the bridge's view; slave is the requester/subordinate environment.
interface apb3_manager_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb3_manager_bridge.sv
// Turns valid/ready requests into single outstanding APB3 transfers, with a watchdog
// that aborts an ACCESS phase whose subordinate never raises PREADY.
module apb3_manager_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  apb3_manager_bridge_if.master bus
);

  localparam bit             WATCHDOG_ON = (TIMEOUT_CYCLES > 0);
  localparam int             CW          = WATCHDOG_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  LAST_WAIT   = WATCHDOG_ON ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  req_ready;
  logic                  accept;
  logic                  complete;
  logic                  abort;
  logic [CW-1:0]         wait_cnt;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // The unused encoding falls back to IDLE without offering REQ_READY.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.REQ_VALID) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (WATCHDOG_ON && (wait_cnt == LAST_WAIT)) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      psel      <= (next_state == SETUP) || (next_state == ACCESS);
      penable   <= (next_state == ACCESS);
      rsp_valid <= complete || abort;
      if (accept) begin
        pwrite <= bus.REQ_WRITE;
        paddr  <= bus.REQ_ADDR;
        pwdata <= bus.REQ_WRITE ? bus.REQ_WDATA : '0;
      end
      if (complete) begin
        rsp_rdata <= pwrite ? '0 : bus.PRDATA;
        rsp_err   <= bus.PSLVERR;
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
      // The counter only ever reaches LAST_WAIT before an abort, so it cannot wrap.
      if (state == SETUP)
        wait_cnt <= '0;
      else if ((state == ACCESS) && !bus.PREADY && WATCHDOG_ON)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite;
  assign bus.PADDR     = paddr;
  assign bus.PWDATA    = pwdata;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_ERR   = rsp_err;
  assign bus.RSP_RDATA = rsp_rdata;

endmodule

// File: tb/tb_apb3_manager_bridge.sv
// Self-checking bench for apb3_manager_bridge: a reactive APB3 subordinate plus a
// transaction-level model predicting latency, ACCESS length and the response.
module tb_apb3_manager_bridge;

  localparam int T = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  int          o_lat;
  int          o_access;
  int          o_shape_bad;
  int          o_stable_bad;
  logic        o_ready;
  logic        o_err;
  logic        o_psel_rsp;
  logic [31:0] o_rdata;

  int          e_lat;
  int          e_access;
  logic        e_err;
  logic [31:0] e_rdata;

  apb3_manager_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb3_manager_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level expectation: n refused ACCESS cycles either finish at n+1 or hit the watchdog at T.
  task automatic predict(input logic w, input int n, input logic [31:0] rdata, input logic err);
    logic timed_out;
    timed_out = (n >= T);
    e_access  = timed_out ? T : n + 1;
    e_lat     = e_access + 2;
    e_err     = timed_out ? 1'b1 : err;
    e_rdata   = (timed_out || w) ? 32'h0 : rdata;
  endtask

  task automatic idle(input int k);
    bus.REQ_VALID = 1'b0;
    bus.PREADY    = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  // Presents one request at the current negedge and plays the subordinate until RSP_VALID is seen.
  task automatic run_transfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                              input int n, input logic [31:0] rdata, input logic err,
                              input logic hold_valid);
    int          j;
    logic [31:0] exp_pwdata;
    exp_pwdata    = w ? wdata : 32'h0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = w;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    bus.PREADY    = 1'($urandom_range(0, 1));
    bus.PSLVERR   = 1'b1;
    bus.PRDATA    = $urandom;
    o_ready = bus.REQ_READY;
    o_lat = -1; o_access = 0; o_shape_bad = 0; o_stable_bad = 0;
    o_err = 1'bx; o_rdata = 'x; o_psel_rsp = 1'bx;
    j = 0;
    for (int idx = 1; idx <= 40 && o_lat < 0; idx++) begin
      @(negedge clk);
      if (bus.PADDR !== addr || bus.PWRITE !== w || bus.PWDATA !== exp_pwdata) o_stable_bad++;
      if (bus.RSP_VALID === 1'b1) begin
        o_lat      = idx;
        o_err      = bus.RSP_ERR;
        o_rdata    = bus.RSP_RDATA;
        o_psel_rsp = bus.PSEL | bus.PENABLE;
      end else begin
        if (idx == 1 ? !(bus.PSEL === 1'b1 && bus.PENABLE === 1'b0)
                     : !(bus.PSEL === 1'b1 && bus.PENABLE === 1'b1)) o_shape_bad++;
        bus.REQ_VALID = hold_valid;
        bus.REQ_WRITE = 1'($urandom_range(0, 1));
        bus.REQ_ADDR  = $urandom;
        bus.REQ_WDATA = $urandom;
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
          o_access++;
          j++;
          bus.PREADY = (j > n);
        end else begin
          bus.PREADY = 1'($urandom_range(0, 1));
        end
        bus.PSLVERR = bus.PREADY ? err : 1'b1;
        bus.PRDATA  = bus.PREADY ? rdata : $urandom;
      end
    end
  endtask

  task automatic test_reset;
    bus.REQ_VALID = 0; bus.REQ_WRITE = 0; bus.REQ_ADDR = 0; bus.REQ_WDATA = 0;
    bus.PRDATA = 0; bus.PREADY = 0; bus.PSLVERR = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL reset REQ_READY got %b exp 1", bus.REQ_READY); end
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin fails++; $display("[TB] FAIL reset PSEL/PENABLE/PWRITE got %b exp 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    checks++; if ({bus.RSP_VALID, bus.RSP_ERR} !== 2'b00) begin fails++; $display("[TB] FAIL reset RSP_VALID/RSP_ERR got %b exp 00", {bus.RSP_VALID, bus.RSP_ERR}); end
    checks++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin fails++; $display("[TB] FAIL reset PADDR/PWDATA got %h/%h exp 0/0", bus.PADDR, bus.PWDATA); end
    checks++; if (bus.RSP_RDATA !== 32'h0) begin fails++; $display("[TB] FAIL reset RSP_RDATA got %h exp 0", bus.RSP_RDATA); end
  endtask

  task automatic test_write_zero_wait;
    logic [31:0] junk;
    junk = $urandom | 32'h1;
    predict(1'b1, 0, junk, 1'b0);
    run_transfer(1'b1, 32'h10, 32'hDEADBEEF, 0, junk, 1'b0, 1'b0);
    checks++; if (o_ready !== 1'b1) begin fails++; $display("[TB] FAIL wr0 ready got %b exp 1", o_ready); end
    checks++; if (o_lat !== e_lat) begin fails++; $display("[TB] FAIL wr0 latency got %0d exp %0d", o_lat, e_lat); end
    checks++; if (o_shape_bad !== 0 || o_access !== e_access) begin fails++; $display("[TB] FAIL wr0 phases got bad=%0d access=%0d exp 0/%0d", o_shape_bad, o_access, e_access); end
    checks++; if (o_stable_bad !== 0) begin fails++; $display("[TB] FAIL wr0 addr/data stability got %0d bad cycles exp 0", o_stable_bad); end
    checks++; if (o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL wr0 response got err=%b rdata=%h exp %b/%h", o_err, o_rdata, e_err, e_rdata); end
    idle(1);
    checks++; if (bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== e_err || bus.RSP_RDATA !== e_rdata) begin fails++; $display("[TB] FAIL wr0 pulse/hold got v=%b err=%b rdata=%h exp 0/%b/%h", bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA, e_err, e_rdata); end
  endtask

  task automatic test_read_waits;
    predict(1'b0, 2, 32'hA5A5_0001, 1'b0);
    run_transfer(1'b0, 32'h24, 32'h1234_5678, 2, 32'hA5A5_0001, 1'b0, 1'b0);
    checks++; if (o_lat !== e_lat || o_access !== e_access) begin fails++; $display("[TB] FAIL rd2 timing got lat=%0d access=%0d exp %0d/%0d", o_lat, o_access, e_lat, e_access); end
    checks++; if (o_stable_bad !== 0 || o_shape_bad !== 0) begin fails++; $display("[TB] FAIL rd2 bus got stable_bad=%0d shape_bad=%0d exp 0/0", o_stable_bad, o_shape_bad); end
    checks++; if (o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL rd2 response got err=%b rdata=%h exp %b/%h", o_err, o_rdata, e_err, e_rdata); end
    idle(2);
  endtask

  task automatic test_error;
    predict(1'b0, 1, 32'h0BAD_0BAD, 1'b1);
    run_transfer(1'b0, 32'h30, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, 1'b0);
    checks++; if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL slverr got lat=%0d err=%b rdata=%h exp %0d/%b/%h", o_lat, o_err, o_rdata, e_lat, e_err, e_rdata); end
    idle(1);
    predict(1'b0, 3, 32'h1111_2222, 1'b0);
    run_transfer(1'b0, 32'h34, 32'h0, 3, 32'h1111_2222, 1'b0, 1'b0);
    checks++; if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL slverr-while-waiting got lat=%0d err=%b rdata=%h exp %0d/%b/%h", o_lat, o_err, o_rdata, e_lat, e_err, e_rdata); end
    idle(1);
  endtask

  task automatic test_timeout;
    predict(1'b0, 50, 32'hFFFF_FFFF, 1'b0);
    run_transfer(1'b0, 32'h40, 32'h0, 50, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++; if (o_access !== e_access || o_lat !== e_lat) begin fails++; $display("[TB] FAIL timeout timing got access=%0d lat=%0d exp %0d/%0d", o_access, o_lat, e_access, e_lat); end
    checks++; if (o_err !== e_err || o_rdata !== e_rdata || o_psel_rsp !== 1'b0) begin fails++; $display("[TB] FAIL timeout response got err=%b rdata=%h psel=%b exp %b/%h/0", o_err, o_rdata, o_psel_rsp, e_err, e_rdata); end
    idle(1);
    predict(1'b0, T - 1, 32'h5EED_CAFE, 1'b0);
    run_transfer(1'b0, 32'h44, 32'h0, T - 1, 32'h5EED_CAFE, 1'b0, 1'b0);
    checks++; if (o_access !== e_access || o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL ready-on-last-cycle got access=%0d err=%b rdata=%h exp %0d/%b/%h", o_access, o_err, o_rdata, e_access, e_err, e_rdata); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] data;
    for (int k = 0; k < 3; k++) begin
      data = 32'hC0DE_0000 + 32'(k);
      predict(1'b1, 0, 32'h0, 1'b0);
      run_transfer(1'b1, 32'h100 + 32'(4 * k), data, 0, $urandom, 1'b0, 1'b1);
      checks++; if (o_ready !== 1'b1 || o_lat !== e_lat || o_stable_bad !== 0 || o_shape_bad !== 0 || o_psel_rsp !== 1'b0) begin fails++; $display("[TB] FAIL b2b[%0d] got ready=%b lat=%0d stable_bad=%0d shape_bad=%0d psel_at_rsp=%b exp 1/%0d/0/0/0", k, o_ready, o_lat, o_stable_bad, o_shape_bad, o_psel_rsp, e_lat); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int stray;
    bus.REQ_VALID = 1'b1; bus.REQ_WRITE = 1'b1; bus.REQ_ADDR = 32'h80; bus.REQ_WDATA = 32'h7777_7777;
    @(negedge clk);
    bus.REQ_VALID = 1'b0; bus.PREADY = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.RSP_VALID} !== 3'b000) begin fails++; $display("[TB] FAIL async reset got PSEL/PENABLE/RSP_VALID=%b exp 000", {bus.PSEL, bus.PENABLE, bus.RSP_VALID}); end
    checks++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin fails++; $display("[TB] FAIL async reset got PADDR/PWDATA=%h/%h exp 0/0", bus.PADDR, bus.PWDATA); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.PREADY = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.RSP_VALID !== 1'b0 || bus.PSEL !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin fails++; $display("[TB] FAIL killed transfer activity got %0d cycles exp 0", stray); end
    predict(1'b0, 1, 32'h600D_F00D, 1'b0);
    run_transfer(1'b0, 32'h84, 32'h0, 1, 32'h600D_F00D, 1'b0, 1'b0);
    checks++; if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata) begin fails++; $display("[TB] FAIL after-reset read got lat=%0d err=%b rdata=%h exp %0d/%b/%h", o_lat, o_err, o_rdata, e_lat, e_err, e_rdata); end
    idle(1);
  endtask

  task automatic test_random;
    logic        w, err, b2b;
    logic [31:0] addr, wdata, rdata;
    int          n;
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1)); err = 1'($urandom_range(0, 1)); b2b = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom; rdata = $urandom; n = $urandom_range(0, 5);
      predict(w, n, rdata, err);
      run_transfer(w, addr, wdata, n, rdata, err, b2b);
      checks++; if (o_ready !== 1'b1 || o_lat !== e_lat || o_access !== e_access || o_shape_bad !== 0 || o_stable_bad !== 0 || o_err !== e_err || o_rdata !== e_rdata) begin
        fails++;
        $display("[TB] FAIL rand[%0d] w=%b n=%0d got ready=%b lat=%0d acc=%0d shape=%0d stab=%0d err=%b rd=%h exp 1/%0d/%0d/0/0/%b/%h",
                 k, w, n, o_ready, o_lat, o_access, o_shape_bad, o_stable_bad, o_err, o_rdata, e_lat, e_access, e_err, e_rdata);
      end
      if (!b2b) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_write_zero_wait;
    test_read_waits;
    test_error;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
